// File: rtl/sample_pkg.sv
// sample_pkg: shared sample/frame defaults, fill-width helper and output-register state type.
package sample_pkg;
  localparam int DEF_SAMPLE_W    = 8;
  localparam int DEF_NUM_SAMPLES = 8;
  localparam int DEF_DIV_W       = 16;
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: registered one-cycle strobe every max(div,1) cycles while enabled.
module tick_divider
  import sample_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             fastclk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             sample_tick
);
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_cnt_next;
  assign w_last     = (div == '0) ? '0 : div - DIV_W'(1);
  assign w_cnt_next = r_tick ? '0 : r_cnt + DIV_W'(1);
  // tick is decided one cycle ahead; >= lets a shrunken div fire on the very next cycle
  always_ff @(posedge fastclk)
    if (rst || !enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= w_cnt_next >= w_last;
    end
  assign sample_tick = r_tick;
endmodule

// File: rtl/sample_packer.sv
// sample_packer: packs NUM_SAMPLES strobed samples into a frame held in a valid/ready output register.
module sample_packer
  import sample_pkg::*;
#(
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int DIV_W       = DEF_DIV_W
) (
  input  logic                            fastclk,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                div,
  input  logic [SAMPLE_W-1:0]             sample_in,
  input  logic                            enable,
  output logic [SAMPLE_W*NUM_SAMPLES-1:0] out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sample_tick,
  output logic [fill_w(NUM_SAMPLES)-1:0]  fill,
  output logic                            overflow,
  input  logic                            ovf_clr
);
  localparam int FW = fill_w(NUM_SAMPLES);
  logic                                 w_tick;
  logic                                 w_done;
  logic [SAMPLE_W*NUM_SAMPLES-1:0]      w_frame;
  logic [NUM_SAMPLES-2:0][SAMPLE_W-1:0] r_buf;
  logic [FW-1:0]                        r_fill;
  logic [SAMPLE_W*NUM_SAMPLES-1:0]      r_out;
  out_state_t                           r_state;
  logic                                 r_ovf;

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .fastclk    (fastclk),
    .rst        (rst),
    .enable     (enable),
    .div        (div),
    .sample_tick(w_tick)
  );

  assign w_done  = w_tick && r_fill == FW'(NUM_SAMPLES - 1);
  // the final sample bypasses the buffer and goes straight into the frame
  assign w_frame = {sample_in, r_buf};

  always_ff @(posedge fastclk)
    if (rst) begin
      r_buf   <= '0;
      r_fill  <= '0;
      r_out   <= '0;
      r_state <= OUT_EMPTY;
      r_ovf   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SAMPLES - 1; k++)
        if (w_tick && r_fill == FW'(k)) r_buf[k] <= sample_in;
      if (w_tick) r_fill <= w_done ? '0 : r_fill + FW'(1);
      case (r_state)
        OUT_EMPTY: if (w_done) begin
          r_out   <= w_frame;
          r_state <= OUT_FULL;
        end
        OUT_FULL: if (w_done && out_ready) r_out <= w_frame;
                  else if (out_ready) r_state <= OUT_EMPTY;
      endcase
      if (w_done && r_state == OUT_FULL && !out_ready) r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end

  assign out         = r_out;
  assign out_valid   = r_state == OUT_FULL;
  assign sample_tick = w_tick;
  assign fill        = r_fill;
  assign overflow    = r_ovf;
endmodule
